pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: combines flush, memory wait-states, multi-cycle EX
// operations and ID load-use requests into one prioritised stage-hold vector.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        ex_mc_start,
    input  logic [5:0]  ex_mc_cycles,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        flush_req,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        ex_mc_done,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    typedef enum logic {M_IDLE, M_WAIT} mstate_t;

    mstate_t    mstate;
    logic [7:0] wait_cnt;
    logic [5:0] ex_cnt;
    logic       mem_stall;
    logic       mem_abort;
    logic       ex_accept;
    logic       ex_busy;

    always_comb begin
        mem_stall = 1'b0;
        mem_abort = 1'b0;
        case (mstate)
            M_IDLE: mem_stall = mem_req && !mem_ack;
            M_WAIT: begin
                mem_stall = !mem_ack && (wait_cnt != TMO);
                mem_abort = !mem_ack && (wait_cnt == TMO);
            end
            default: ;
        endcase
    end

    // stall[3] can only come from MEM while EX is idle, so the acceptance
    // test uses mem_stall directly and avoids a loop through ex_busy.
    assign ex_accept = ex_mc_start && (ex_cnt == 6'd0) && !mem_stall && !flush_req && !rst;
    assign ex_busy   = ex_accept || (ex_cnt > 6'd1);

    always_comb begin
        stall = 6'b000000;
        if (!rst && !flush_req) begin
            if (mem_stall)             stall = 6'b011111;
            else if (ex_busy)          stall = 6'b001111;
            else if (stallreq_from_id) stall = 6'b000111;
        end
    end

    assign flush       = flush_req && !rst;
    assign ex_mc_done  = (ex_cnt == 6'd1) && !flush_req && !rst;
    assign mem_timeout = mem_abort && !flush_req && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_cnt       <= 6'd0;
            mstate       <= M_IDLE;
            wait_cnt     <= 8'd0;
            stall_cycles <= 16'd0;
        end else begin
            if ((stall != 6'b000000) && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;

            if (flush_req) begin
                ex_cnt   <= 6'd0;
                mstate   <= M_IDLE;
                wait_cnt <= 8'd0;
            end else begin
                if (ex_accept)
                    ex_cnt <= (ex_mc_cycles == 6'd0) ? 6'd1 : ex_mc_cycles;
                else if (ex_cnt != 6'd0)
                    ex_cnt <= ex_cnt - 6'd1;

                case (mstate)
                    M_IDLE: begin
                        if (mem_req && !mem_ack) begin
                            mstate   <= M_WAIT;
                            wait_cnt <= 8'd1;
                        end
                    end
                    M_WAIT: begin
                        if (mem_ack || mem_abort) begin
                            mstate   <= M_IDLE;
                            wait_cnt <= 8'd0;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                    default: mstate <= M_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with MEM_TIMEOUT=4; every expected value is hand-derived.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_from_id;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_cycles;
    logic        mem_req;
    logic        mem_ack;
    logic        flush_req;
    logic [5:0]  stall;
    logic        flush;
    logic        ex_mc_done;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .stallreq_from_id(stallreq_from_id),
        .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles),
        .mem_req(mem_req), .mem_ack(mem_ack), .flush_req(flush_req),
        .stall(stall), .flush(flush), .ex_mc_done(ex_mc_done),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Check the combinational outputs mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [5:0] e_stall, input logic e_flush,
                       input logic e_done, input logic e_to);
        #2;
        chk({tag, ".stall"}, 16'(stall), 16'(e_stall));
        chk({tag, ".flush"}, 16'(flush), 16'(e_flush));
        chk({tag, ".done"},  16'(ex_mc_done), 16'(e_done));
        chk({tag, ".tmo"},   16'(mem_timeout), 16'(e_to));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        stallreq_from_id = 0; ex_mc_start = 0; ex_mc_cycles = 0;
        mem_req = 0; mem_ack = 0; flush_req = 0;
    endtask

    initial begin
        @(negedge clk);
        // Reset with busy inputs: outputs must stay quiet.
        rst = 1; stallreq_from_id = 1; ex_mc_start = 1; ex_mc_cycles = 3;
        mem_req = 1; mem_ack = 0; flush_req = 0;
        cyc("rst", 6'b000000, 0, 0, 0);
        flush_req = 1;
        cyc("rst_fl", 6'b000000, 0, 0, 0);
        rst = 0; idle_in();
        chk("rst.cnt", stall_cycles, 16'd0);
        cyc("idle", 6'b000000, 0, 0, 0);

        // ID load-use request, single cycle
        stallreq_from_id = 1;
        cyc("id", 6'b000111, 0, 0, 0);
        idle_in();
        cyc("id_off", 6'b000000, 0, 0, 0);
        chk("id.cnt", stall_cycles, 16'd1);

        // EX N=4, with an ignored restart mid-operation
        ex_mc_start = 1; ex_mc_cycles = 4;
        cyc("ex4_0", 6'b001111, 0, 0, 0);
        ex_mc_start = 0;
        cyc("ex4_1", 6'b001111, 0, 0, 0);
        ex_mc_start = 1; ex_mc_cycles = 9;
        cyc("ex4_2", 6'b001111, 0, 0, 0);
        ex_mc_start = 0;
        cyc("ex4_3", 6'b001111, 0, 0, 0);
        cyc("ex4_done", 6'b000000, 0, 1, 0);
        cyc("ex4_after", 6'b000000, 0, 0, 0);
        chk("ex4.cnt", stall_cycles, 16'd5);

        // EX N=0 treated as 1
        ex_mc_start = 1; ex_mc_cycles = 0;
        cyc("ex0_0", 6'b001111, 0, 0, 0);
        idle_in();
        cyc("ex0_done", 6'b000000, 0, 1, 0);
        cyc("ex0_after", 6'b000000, 0, 0, 0);
        chk("ex0.cnt", stall_cycles, 16'd6);

        // MEM wait beats ID and EX; EX start accepted once MEM releases
        mem_req = 1; stallreq_from_id = 1; ex_mc_start = 1; ex_mc_cycles = 2;
        cyc("mem_0", 6'b011111, 0, 0, 0);
        cyc("mem_1", 6'b011111, 0, 0, 0);
        mem_ack = 1;
        cyc("mem_ack", 6'b001111, 0, 0, 0);
        idle_in();
        cyc("mem_ex", 6'b001111, 0, 0, 0);
        cyc("mem_exd", 6'b000000, 0, 1, 0);
        chk("mem.cnt", stall_cycles, 16'd10);

        // MEM timeout after 4 stall cycles
        mem_req = 1;
        cyc("to_0", 6'b011111, 0, 0, 0);
        cyc("to_1", 6'b011111, 0, 0, 0);
        cyc("to_2", 6'b011111, 0, 0, 0);
        cyc("to_3", 6'b011111, 0, 0, 0);
        cyc("to_4", 6'b000000, 0, 0, 1);
        mem_ack = 1;
        cyc("to_idle", 6'b000000, 0, 0, 0);
        chk("to.cnt", stall_cycles, 16'd14);

        // Stray ack in M_IDLE is ignored
        mem_req = 0; mem_ack = 1;
        cyc("stray", 6'b000000, 0, 0, 0);
        mem_req = 1; mem_ack = 0;
        cyc("stray_w", 6'b011111, 0, 0, 0);
        mem_ack = 1;
        cyc("stray_a", 6'b000000, 0, 0, 0);
        idle_in();
        chk("stray.cnt", stall_cycles, 16'd15);

        // Flush with ex_cnt=3, then a fresh start is accepted
        ex_mc_start = 1; ex_mc_cycles = 5;
        cyc("fl_0", 6'b001111, 0, 0, 0);
        ex_mc_start = 0;
        cyc("fl_1", 6'b001111, 0, 0, 0);
        cyc("fl_2", 6'b001111, 0, 0, 0);
        flush_req = 1; stallreq_from_id = 1;
        cyc("fl_3", 6'b000000, 1, 0, 0);
        flush_req = 0; stallreq_from_id = 0; ex_mc_start = 1; ex_mc_cycles = 1;
        cyc("fl_new", 6'b001111, 0, 0, 0);
        idle_in();
        cyc("fl_done", 6'b000000, 0, 1, 0);
        cyc("fl_after", 6'b000000, 0, 0, 0);
        chk("fl.cnt", stall_cycles, 16'd19);

        // Reset during M_WAIT, then immediate ack sees M_IDLE
        mem_req = 1;
        cyc("rw_0", 6'b011111, 0, 0, 0);
        rst = 1; stallreq_from_id = 1;
        cyc("rw_rst", 6'b000000, 0, 0, 0);
        rst = 0; stallreq_from_id = 0; mem_ack = 1;
        cyc("rw_ack", 6'b000000, 0, 0, 0);
        chk("rw.cnt", stall_cycles, 16'd0);
        idle_in();
        cyc("rw_idle", 6'b000000, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
